stereo_pan_mixer: RTL and testbench
===================================

# stereo_pan_mixer

Consumer of the auto-panner's pan position. Takes a mono 16-bit signed audio sample plus a 16-bit pan word, where 0x0000 is full left, 0x4000 is centre and 0x7FFF is full right. Produces gain-scaled left and right samples for the stereo output stage. A single shared multiplier is time-multiplexed across the two channels, and a per-sample slew limiter on the pan position suppresses zipper noise when the pan word jumps.

## Interface
Parameters:
- SLEW_STEP, 16'h0080: maximum change of the applied pan position per accepted sample. 0 disables slew, so the target is applied immediately.

Ports:
- CLK, input, 1: system clock. All state is updated on its rising edge.
- RESET, input, 1: asynchronous, active-high reset.
- SAMPLE_IN, input, 16: mono sample, signed two's complement.
- SAMPLE_VALID, input, 1: one-cycle strobe that offers SAMPLE_IN.
- PAN_IN, input, 16: target pan position, read as signed.
- PAN_EN, input, 1: 1 means use PAN_IN; 0 forces the target to 16'h4000.
- L_OUT, output, 16: left sample, signed, registered.
- R_OUT, output, 16: right sample, signed, registered.
- OUT_VALID, output, 1: one-cycle pulse when L_OUT and R_OUT update together.
- BUSY, output, 1: high while a sample is in flight.

## Operation
- Target pan (tgt):
  - PAN_EN=0: tgt = 0x4000.
  - PAN_IN[15]=1 (negative): tgt = 0x0000.
  - Otherwise: tgt = PAN_IN.
  - tgt is sampled in the SLEW state.
- Applied pan (pcur): 16-bit register, reset value 0x4000, range 0x0000..0x7FFF. In the SLEW state:
  - SLEW_STEP=0: pcur = tgt.
  - |tgt − pcur| ≤ SLEW_STEP: pcur = tgt.
  - Otherwise: pcur moves one SLEW_STEP toward tgt.
- Gains:
  - gL = 0x7FFF − pcur.
  - gR = pcur.
  - Both are 15-bit unsigned values, zero-extended to a signed 16-bit multiplier operand.
- Multiply:
  - Product is samp × g, signed 32-bit.
  - Result is product >>> 15 (arithmetic shift, floor), then bits [15:0].
  - The result range is −32767..32767, so no saturation is needed.
- FSM states: IDLE → SLEW → MUL_L → MUL_R → DONE → IDLE.
  - IDLE: BUSY=0. When SAMPLE_VALID=1, latch SAMPLE_IN into samp and go to SLEW.
  - SLEW: update pcur.
  - MUL_L: multiplier computes samp × gL into an internal register.
  - MUL_R: multiplier computes samp × gR.
  - DONE: L_OUT and R_OUT load together and OUT_VALID=1 for this single cycle.
- SAMPLE_VALID in any state other than IDLE is ignored: no queueing and no effect on the in-flight sample.
- Outputs hold their last value between OUT_VALID pulses.

## Timing
- Reset values (asynchronous): L_OUT=0, R_OUT=0, OUT_VALID=0, BUSY=0, pcur=0x4000, FSM=IDLE, samp=0.
- Latency:
  - SAMPLE_VALID high in IDLE at edge N.
  - BUSY=1 from N+1 through N+4.
  - OUT_VALID=1 and new L_OUT/R_OUT during cycle N+4.
  - Back in IDLE at N+5, which can accept a new strobe there.
  - Minimum sample spacing is 5 cycles.
- PAN_IN and PAN_EN changes take effect only at the next SLEW state. Mid-flight changes do not alter the sample already in flight.
- RESET asserted mid-operation aborts the sample: no OUT_VALID, all reset values restored immediately.
- After RESET is released, the first edge with SAMPLE_VALID=1 in IDLE starts a normal transaction.

## Test plan
1. Centre pan:
   - Stimulus: PAN_EN=1, PAN_IN=0x4000, SAMPLE_IN=0x4000.
   - Response: L_OUT=0x1FFF, R_OUT=0x2000, OUT_VALID exactly 4 cycles after the strobe edge.
2. Hard left, slew disabled:
   - Stimulus: SLEW_STEP=0, PAN_IN=0x0000, SAMPLE_IN=0x7FFF.
   - Response: L_OUT=0x7FFE, R_OUT=0x0000.
3. Hard right, negative sample:
   - Stimulus: SLEW_STEP=0, PAN_IN=0x7FFF, SAMPLE_IN=0x8000.
   - Response: L_OUT=0x0000, R_OUT=0x8001.
   - Also: PAN_IN=0xC000 behaves exactly like PAN_IN=0x0000.
4. Slew:
   - Stimulus: default SLEW_STEP, pcur=0x4000, PAN_IN=0x7FFF, SAMPLE_IN=0x7FFF, repeated samples.
   - Response: the 1st sample uses pcur=0x4080 (R_OUT=0x407F). pcur reaches 0x7F80 at sample 127 and 0x7FFF at sample 128.
   - Follow-up: setting PAN_EN=0 slews pcur back toward 0x4000 at the same rate.
5. Busy drop:
   - Stimulus: strobes at cycles 0 and 2 carrying different samples.
   - Response: exactly one OUT_VALID, at cycle 4, reflecting only the first sample. A strobe at cycle 5 is accepted.
6. Reset mid-flight:
   - Stimulus: assert RESET during MUL_L, asynchronously between clock edges.
   - Response: outputs go to 0 and BUSY goes low without waiting for a clock edge. No OUT_VALID. pcur=0x4000. A subsequent transaction matches scenario 1.

Source files
------------

// File: rtl/stereo_pan_mixer.sv
// ---------------------------------------------------------------------------
// stereo_pan_mixer: mono-to-stereo pan with slew-limited pan and one shared multiplier
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stereo_pan_mixer #(
  parameter logic [15:0] SLEW_STEP = 16'h0080
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] SAMPLE_IN,
  input  logic        SAMPLE_VALID,
  input  logic [15:0] PAN_IN,
  input  logic        PAN_EN,
  output logic [15:0] L_OUT,
  output logic [15:0] R_OUT,
  output logic        OUT_VALID,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SLEW  = 3'd1,
    S_MUL_L = 3'd2,
    S_MUL_R = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] samp_q, samp_d;
  logic [15:0] pcur_q, pcur_d;
  logic [15:0] prod_l_q, prod_l_d;
  logic [15:0] l_out_q, l_out_d;
  logic [15:0] r_out_q, r_out_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;

  logic [15:0]        w_tgt;
  logic signed [16:0] w_diff;
  logic [16:0]        w_dist;
  logic [15:0]        w_pcur_slewed;
  logic [14:0]        w_gain;
  logic signed [31:0] w_product;
  logic [15:0]        w_mul_res;
  logic               unused_bits;

  // Negative pan words clamp to hard left; pan disabled means centre.
  assign w_tgt = !PAN_EN    ? 16'h4000 :
                 PAN_IN[15] ? 16'h0000 : PAN_IN;

  assign w_diff = $signed({1'b0, w_tgt}) - $signed({1'b0, pcur_q});
  assign w_dist = w_diff[16] ? 17'(-w_diff) : 17'(w_diff);

  always_comb begin
    w_pcur_slewed = w_tgt;
    if (SLEW_STEP != 16'd0 && w_dist > {1'b0, SLEW_STEP}) begin
      w_pcur_slewed = w_diff[16] ? (pcur_q - SLEW_STEP) : (pcur_q + SLEW_STEP);
    end
  end

  // One multiplier: left gain in MUL_L, right gain otherwise.
  assign w_gain    = (state_q == S_MUL_L) ? (15'h7FFF - pcur_q[14:0]) : pcur_q[14:0];
  assign w_product = $signed(samp_q) * $signed({1'b0, w_gain});
  // Bits [30:15] equal (product >>> 15)[15:0]; gain is non-negative so bit 31 adds nothing.
  assign w_mul_res = w_product[30:15];
  assign unused_bits = ^{w_product[31], w_product[14:0], pcur_q[15]};

  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    pcur_d      = pcur_q;
    prod_l_d    = prod_l_q;
    l_out_d     = l_out_q;
    r_out_d     = r_out_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (SAMPLE_VALID) begin
          samp_d  = SAMPLE_IN;
          state_d = S_SLEW;
        end
      end
      S_SLEW: begin
        pcur_d  = w_pcur_slewed;
        state_d = S_MUL_L;
      end
      S_MUL_L: begin
        prod_l_d = w_mul_res;
        state_d  = S_MUL_R;
      end
      S_MUL_R: begin
        l_out_d     = prod_l_q;
        r_out_d     = w_mul_res;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      samp_q      <= 16'h0000;
      pcur_q      <= 16'h4000;
      prod_l_q    <= 16'h0000;
      l_out_q     <= 16'h0000;
      r_out_q     <= 16'h0000;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_q      <= samp_d;
      pcur_q      <= pcur_d;
      prod_l_q    <= prod_l_d;
      l_out_q     <= l_out_d;
      r_out_q     <= r_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign L_OUT     = l_out_q;
  assign R_OUT     = r_out_q;
  assign OUT_VALID = out_valid_q;
  assign BUSY      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_stereo_pan_mixer.sv
// ---------------------------------------------------------------------------
// tb_stereo_pan_mixer: random and directed checks of two mixers (default slew, slew off)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stereo_pan_mixer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample_in, pan_in;
  logic        sample_valid, pan_en;
  logic [15:0] l_a, r_a, l_b, r_b;
  logic        ov_a, ov_b, busy_a, busy_b;

  int n_checks = 0;
  int n_errors = 0;
  int pa = 16384;  // expected applied pan, default-slew instance
  int pb = 16384;  // expected applied pan, slew-disabled instance

  always #5 clk = ~clk;

  stereo_pan_mixer u_dut_a (
    .CLK(clk), .RESET(rst), .SAMPLE_IN(sample_in), .SAMPLE_VALID(sample_valid),
    .PAN_IN(pan_in), .PAN_EN(pan_en), .L_OUT(l_a), .R_OUT(r_a),
    .OUT_VALID(ov_a), .BUSY(busy_a)
  );

  stereo_pan_mixer #(.SLEW_STEP(16'h0000)) u_dut_b (
    .CLK(clk), .RESET(rst), .SAMPLE_IN(sample_in), .SAMPLE_VALID(sample_valid),
    .PAN_IN(pan_in), .PAN_EN(pan_en), .L_OUT(l_b), .R_OUT(r_b),
    .OUT_VALID(ov_b), .BUSY(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int tgt_of(input logic en, input logic [15:0] pan);
    if (!en) return 16384;
    if (pan[15]) return 0;
    return int'(pan);
  endfunction

  function automatic int slew(input int cur, input int tgt, input int step);
    if (step == 0) return tgt;
    if (tgt >= cur) return (tgt - cur <= step) ? tgt : cur + step;
    return (cur - tgt <= step) ? tgt : cur - step;
  endfunction

  // sample * gain / 32768, rounded toward minus infinity
  function automatic logic [15:0] scale(input logic [15:0] s, input int g);
    int p, q;
    p = int'($signed(s)) * g;
    q = p / 32768;
    if (p < 0 && q * 32768 != p) q = q - 1;
    return 16'(q);
  endfunction

  // Called at a negedge with the DUTs idle; returns at the negedge after they are idle again.
  task automatic run_sample(input logic [15:0] s, input logic [15:0] pan, input logic en,
                            input bit dbl);
    int tgt;
    logic [15:0] ela, era, elb, erb;
    tgt = tgt_of(en, pan);
    pa  = slew(pa, tgt, 128);
    pb  = slew(pb, tgt, 0);
    ela = scale(s, 32767 - pa);
    era = scale(s, pa);
    elb = scale(s, 32767 - pb);
    erb = scale(s, pb);
    sample_in = s; pan_in = pan; pan_en = en; sample_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        sample_valid = 1'b0;
        sample_in = 16'($urandom);
      end
      if (c == 1) begin
        pan_in = 16'($urandom);
        pan_en = 1'($urandom);
        if (dbl) begin
          sample_in = 16'($urandom);
          sample_valid = 1'b1;
        end
      end
      if (c == 2) sample_valid = 1'b0;
      check("ov_a", 32'(ov_a), 32'(c == 3));
      check("ov_b", 32'(ov_b), 32'(c == 3));
      check("busy_a", 32'(busy_a), 32'(c <= 3));
      check("busy_b", 32'(busy_b), 32'(c <= 3));
      if (c >= 3) begin
        check("l_a", 32'(l_a), 32'(ela));
        check("r_a", 32'(r_a), 32'(era));
        check("l_b", 32'(l_b), 32'(elb));
        check("r_b", 32'(r_b), 32'(erb));
      end
    end
  endtask

  initial begin
    rst = 1'b1; sample_in = 16'h0; pan_in = 16'h4000; pan_en = 1'b1; sample_valid = 1'b0;
    #12;
    check("rst_l", 32'(l_a), 32'h0);
    check("rst_r", 32'(r_a), 32'h0);
    check("rst_ov", 32'(ov_a), 32'h0);
    check("rst_busy", 32'(busy_b), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // centre pan
    run_sample(16'h4000, 16'h4000, 1'b1, 1'b0);
    check("centre_l", 32'(l_a), 32'h1FFF);
    check("centre_r", 32'(r_a), 32'h2000);

    // hard left / hard right / negative pan on the slew-disabled instance
    run_sample(16'h7FFF, 16'h0000, 1'b1, 1'b0);
    check("left_l", 32'(l_b), 32'h7FFE);
    check("left_r", 32'(r_b), 32'h0000);
    run_sample(16'h8000, 16'h7FFF, 1'b1, 1'b0);
    check("right_l", 32'(l_b), 32'h0000);
    check("right_r", 32'(r_b), 32'h8001);
    run_sample(16'h7FFF, 16'hC000, 1'b1, 1'b0);
    check("negpan_l", 32'(l_b), 32'h7FFE);
    check("negpan_r", 32'(r_b), 32'h0000);

    // slew from centre to full right, then back toward centre with pan disabled
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; pa = 16384; pb = 16384;
    for (int i = 1; i <= 128; i++) begin
      run_sample(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
      if (i == 1)   check("slew1_r", 32'(r_a), 32'h407F);
      if (i == 127) check("slew127_r", 32'(r_a), 32'h7F7F);
      if (i == 128) check("slew128_r", 32'(r_a), 32'h7FFE);
    end
    for (int i = 1; i <= 3; i++) begin
      run_sample(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
      if (i == 1) check("slewback_r", 32'(r_a), 32'h7F7E);
    end

    // second strobe while busy is dropped
    run_sample(16'h1234, 16'h2000, 1'b1, 1'b1);
    run_sample(16'hABCD, 16'h6000, 1'b1, 1'b1);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      run_sample(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    // asynchronous reset during MUL_L
    run_sample(16'h4000, 16'h4000, 1'b1, 1'b0);
    sample_in = 16'h1234; pan_in = 16'h7FFF; pan_en = 1'b1; sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_l", 32'(l_a), 32'h0);
    check("arst_r", 32'(r_a), 32'h0);
    check("arst_busy", 32'(busy_a), 32'h0);
    check("arst_ov", 32'(ov_a), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_hold_ov", 32'(ov_a), 32'h0);
    end
    rst = 1'b0; pa = 16384; pb = 16384;
    run_sample(16'h4000, 16'h4000, 1'b1, 1'b0);
    check("post_rst_l", 32'(l_a), 32'h1FFF);
    check("post_rst_r", 32'(r_a), 32'h2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
